// File: rtl/uart_tx_scheduler.sv
// UART transmit scheduler: round-robin arbitration between two byte
// requesters and start/data/stop framing of the granted byte, timed from
// an oversampled baud tick. One FSM owns the serial line and its
// bit-sample counter.
//
// Handshake: a requester raises reqN with dataN stable and holds both until
// it sees a one-cycle ackN pulse; the byte is captured on the same edge that
// raises ackN. A requester still high after its ack is a new request.
module uart_tx_scheduler #(
    parameter int DATA_BITS  = 8,
    parameter int OVERSAMPLE = 16
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic                 sample_tick,
    input  logic                 req0,
    input  logic [DATA_BITS-1:0] data0,
    output logic                 ack0,
    input  logic                 req1,
    input  logic [DATA_BITS-1:0] data1,
    output logic                 ack1,
    output logic                 tx_serial,
    output logic                 busy,
    output logic                 active_id
);

    localparam int CNT_W = (OVERSAMPLE > 1) ? $clog2(OVERSAMPLE) : 1;
    localparam int IDX_W = (DATA_BITS > 1) ? $clog2(DATA_BITS) : 1;

    localparam logic [1:0] S_IDLE  = 2'd0;
    localparam logic [1:0] S_START = 2'd1;
    localparam logic [1:0] S_DATA  = 2'd2;
    localparam logic [1:0] S_STOP  = 2'd3;

    logic [1:0]           state;
    logic [CNT_W-1:0]     count;
    logic [IDX_W-1:0]     bit_idx;
    logic [DATA_BITS-1:0] shreg;
    logic [DATA_BITS-1:0] shreg_next;
    logic                 last_id;
    logic                 bit_end;
    logic                 winner;

    // A bit period closes on the tick that completes OVERSAMPLE samples.
    assign bit_end    = sample_tick && (count == CNT_W'(OVERSAMPLE - 1));
    // On a tie the requester not served last wins; otherwise the lone one.
    assign winner     = (req0 && req1) ? ~last_id : req1;
    assign shreg_next = shreg >> 1;

    // Frame FSM: grant, capture, and drive the line bit by bit.
    always_ff @(posedge clk) begin
        if (!rst) begin
            state     <= S_IDLE;
            count     <= '0;
            bit_idx   <= '0;
            shreg     <= '0;
            last_id   <= 1'b1;  // makes requester 0 win the first tie
            ack0      <= 1'b0;
            ack1      <= 1'b0;
            tx_serial <= 1'b1;
            busy      <= 1'b0;
            active_id <= 1'b0;
        end else begin
            ack0 <= 1'b0;
            ack1 <= 1'b0;
            case (state)
                S_IDLE: begin
                    // Ticks here are ignored so the start bit is always full length.
                    count <= '0;
                    if (req0 || req1) begin
                        state     <= S_START;
                        shreg     <= winner ? data1 : data0;
                        ack0      <= ~winner;
                        ack1      <= winner;
                        active_id <= winner;
                        last_id   <= winner;
                        busy      <= 1'b1;
                        tx_serial <= 1'b0;
                        bit_idx   <= '0;
                    end
                end
                S_START: begin
                    if (sample_tick) begin
                        count <= count + CNT_W'(1);
                        if (bit_end) begin
                            state     <= S_DATA;
                            bit_idx   <= '0;
                            tx_serial <= shreg[0];
                        end
                    end
                end
                S_DATA: begin
                    if (sample_tick) begin
                        count <= count + CNT_W'(1);
                        if (bit_end) begin
                            if (bit_idx == IDX_W'(DATA_BITS - 1)) begin
                                state     <= S_STOP;
                                tx_serial <= 1'b1;
                            end else begin
                                shreg     <= shreg_next;
                                bit_idx   <= bit_idx + IDX_W'(1);
                                tx_serial <= shreg_next[0];
                            end
                        end
                    end
                end
                S_STOP: begin
                    if (sample_tick) begin
                        count <= count + CNT_W'(1);
                        if (bit_end) begin
                            state <= S_IDLE;
                            busy  <= 1'b0;
                        end
                    end
                end
                default: begin
                    state     <= S_IDLE;
                    tx_serial <= 1'b1;
                    busy      <= 1'b0;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_uart_tx_scheduler.sv
// Bench for uart_tx_scheduler: table of single-frame vectors plus
// hand-written sequences for ties, back-to-back frames and mid-frame reset.
module tb_uart_tx_scheduler;

    logic       clk;
    logic       rst;
    logic       sample_tick;
    logic       req0;
    logic [7:0] data0;
    logic       ack0;
    logic       req1;
    logic [7:0] data1;
    logic       ack1;
    logic       tx_serial;
    logic       busy;
    logic       active_id;

    int checks;
    int failures;
    int tick_period;
    int tick_ctr;
    int both_ack_cnt;
    bit hold_reqs;
    logic line_buf [0:4095];

    typedef struct {
        bit         r0;
        bit         r1;
        logic [7:0] d0;
        logic [7:0] d1;
        int         period;
        int         idle_pre;
        bit         exp_id;
        logic [7:0] exp_byte;
    } vec_t;

    vec_t vecs [0:3];

    uart_tx_scheduler #(.DATA_BITS(8), .OVERSAMPLE(16)) dut (
        .clk         (clk),
        .rst         (rst),
        .sample_tick (sample_tick),
        .req0        (req0),
        .data0       (data0),
        .ack0        (ack0),
        .req1        (req1),
        .data1       (data1),
        .ack1        (ack1),
        .tx_serial   (tx_serial),
        .busy        (busy),
        .active_id   (active_id)
    );

    // clock and tick generation
    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    always @(posedge clk) begin
        #1;
        if (tick_period <= 0) begin
            sample_tick = 1'b0;
        end else begin
            tick_ctr    = tick_ctr + 1;
            sample_tick = ((tick_ctr % tick_period) == 0);
        end
    end

    always @(negedge clk) begin
        if (ack0 && ack1) both_ack_cnt++;
    end

    task automatic check_val(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s actual=%0h required=%0h", name, act, exp);
        end
    endtask

    task automatic do_reset(input string tag);
        rst  = 1'b0;
        req0 = 1'b0;
        req1 = 1'b0;
        repeat (2) @(negedge clk);
        check_val({tag, "_rst_tx"},    tx_serial, 1);
        check_val({tag, "_rst_busy"},  busy, 0);
        check_val({tag, "_rst_ack0"},  ack0, 0);
        check_val({tag, "_rst_ack1"},  ack1, 0);
        check_val({tag, "_rst_aid"},   active_id, 0);
        rst = 1'b1;
        @(negedge clk);
    endtask

    // wait until the next posedge carries a tick, so the grant edge is tick-aligned
    task automatic align_tick();
        for (int i = 0; i < 300 && !sample_tick; i++) @(negedge clk);
    endtask

    // Waits for a grant, then follows the frame to its end and checks every bit.
    task automatic check_frame(input string tag, input bit exp_id, input logic [7:0] exp_byte,
                               input int p, input int wait_max);
        bit         got;
        int         n;
        int         bl;
        int         stray;
        int         id_bad;
        logic [9:0] bits;
        got = 0;
        for (int i = 0; i < wait_max && !got; i++) begin
            @(negedge clk);
            if (ack0 || ack1) got = 1;
        end
        checks++;
        if (!got) begin
            failures++;
            $display("FAIL %s_grant actual=no_ack required=ack_within_%0d", tag, wait_max);
            return;
        end
        check_val({tag, "_ack0"}, ack0, {31'd0, exp_id == 1'b0});
        check_val({tag, "_ack1"}, ack1, {31'd0, exp_id == 1'b1});
        check_val({tag, "_busy0"}, busy, 1);
        if (!hold_reqs) begin
            req0 = 1'b0;
            req1 = 1'b0;
        end
        bits   = {1'b1, exp_byte, 1'b0};
        bl     = 16 * p;
        n      = 0;
        stray  = 0;
        id_bad = 0;
        while (busy && n < 4000) begin
            line_buf[n] = tx_serial;
            if (n > 0 && (ack0 || ack1)) stray++;
            if (active_id !== exp_id) id_bad++;
            n++;
            @(negedge clk);
        end
        check_val({tag, "_busy_len"}, n, 10 * bl);
        for (int b = 0; b < 10; b++) begin
            check_val($sformatf("%s_bit%0d_first", tag, b), {31'd0, line_buf[b*bl]},          {31'd0, bits[b]});
            check_val($sformatf("%s_bit%0d_mid", tag, b),   {31'd0, line_buf[b*bl + bl/2]},   {31'd0, bits[b]});
            check_val($sformatf("%s_bit%0d_last", tag, b),  {31'd0, line_buf[b*bl + bl - 1]}, {31'd0, bits[b]});
        end
        check_val({tag, "_stray_ack"}, stray, 0);
        check_val({tag, "_aid_steady"}, id_bad, 0);
        check_val({tag, "_idle_tx"}, tx_serial, 1);
        check_val({tag, "_idle_ack"}, {30'd0, ack1, ack0}, 0);
    endtask

    initial begin
        checks       = 0;
        failures     = 0;
        both_ack_cnt = 0;
        tick_ctr     = 0;
        tick_period  = 1;
        hold_reqs    = 0;
        sample_tick  = 1'b0;
        rst          = 1'b0;
        req0         = 1'b0;
        req1         = 1'b0;
        data0        = 8'h00;
        data1        = 8'h00;

        vecs[0] = '{r0: 1, r1: 0, d0: 8'hA5, d1: 8'h00, period: 1, idle_pre: 2,  exp_id: 0, exp_byte: 8'hA5};
        vecs[1] = '{r0: 0, r1: 1, d0: 8'h00, d1: 8'h80, period: 4, idle_pre: 3,  exp_id: 1, exp_byte: 8'h80};
        vecs[2] = '{r0: 1, r1: 0, d0: 8'hFF, d1: 8'h00, period: 1, idle_pre: 21, exp_id: 0, exp_byte: 8'hFF};
        vecs[3] = '{r0: 0, r1: 1, d0: 8'h00, d1: 8'h3C, period: 2, idle_pre: 5,  exp_id: 1, exp_byte: 8'h3C};

        // table-driven single frames
        for (int v = 0; v < 4; v++) begin
            tick_period = vecs[v].period;
            do_reset($sformatf("v%0d", v));
            repeat (vecs[v].idle_pre) @(negedge clk);
            check_val($sformatf("v%0d_idle_busy", v), busy, 0);
            check_val($sformatf("v%0d_idle_tx", v), tx_serial, 1);
            align_tick();
            data0 = vecs[v].d0;
            data1 = vecs[v].d1;
            req0  = vecs[v].r0;
            req1  = vecs[v].r1;
            check_frame($sformatf("v%0d", v), vecs[v].exp_id, vecs[v].exp_byte, vecs[v].period, 2);
        end

        // tie held for four frames: 0,1,0,1 with one-clock gaps
        tick_period = 1;
        do_reset("tie");
        hold_reqs = 1;
        data0 = 8'h11;
        data1 = 8'h22;
        req0  = 1'b1;
        req1  = 1'b1;
        check_frame("tie_f0", 1'b0, 8'h11, 1, 2);
        check_frame("tie_f1", 1'b1, 8'h22, 1, 1);
        check_frame("tie_f2", 1'b0, 8'h11, 1, 1);
        hold_reqs = 0;
        check_frame("tie_f3", 1'b1, 8'h22, 1, 1);

        // reset during data bit 3 of a requester-1 frame
        do_reset("mid");
        data1 = 8'h5A;
        req1  = 1'b1;
        begin
            bit got;
            got = 0;
            for (int i = 0; i < 4 && !got; i++) begin
                @(negedge clk);
                if (ack1) got = 1;
            end
            check_val("mid_grant", {31'd0, got}, 1);
            req1 = 1'b0;
            repeat (70) @(negedge clk);
            check_val("mid_busy_before", busy, 1);
            check_val("mid_aid_before", active_id, 1);
            rst = 1'b0;
            @(negedge clk);
            check_val("mid_tx", tx_serial, 1);
            check_val("mid_busy", busy, 0);
            check_val("mid_ack", {30'd0, ack1, ack0}, 0);
            check_val("mid_aid", active_id, 0);
            rst = 1'b1;
            repeat (20) @(negedge clk);
            check_val("mid_no_retry", busy, 0);
        end
        data0 = 8'h33;
        data1 = 8'h44;
        req0  = 1'b1;
        req1  = 1'b1;
        check_frame("mid_tie", 1'b0, 8'h33, 1, 2);

        check_val("ack_exclusive", both_ack_cnt, 0);
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

    // hard time limit so the run always ends
    initial begin
        #2000000;
        $display("FAIL timeout actual=running required=finished");
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures + 1);
        $finish;
    end

endmodule

// File: doc/uart_tx_scheduler.md
Name: uart_tx_scheduler

Overview:
Transmit-side controller for the UART. It arbitrates two byte requesters (CPU port 0, debug port 1) for a single serial transmitter. It frames each granted byte as start, DATA_BITS data bits LSB first, then stop, and sequences bit timing from an oversampled baud tick. It replaces ad-hoc enable toggling of the transmit bit-sample counter with one FSM that owns the line.

Parameters:
DATA_BITS, 8, data bits per frame (1..16)
OVERSAMPLE, 16, sample_tick pulses per bit period (power of two, 2..256)

Ports:
clk  input  1  system clock
rst  input  1  synchronous reset, active-low (0 = reset)
sample_tick  input  1  one-cycle enable at OVERSAMPLE x baud rate
req0  input  1  requester 0 has a byte; held until ack0
data0  input  DATA_BITS  requester 0 byte; stable while req0 high
ack0  output  1  one-cycle pulse: data0 captured
req1  input  1  requester 1 has a byte; held until ack1
data1  input  DATA_BITS  requester 1 byte; stable while req1 high
ack1  output  1  one-cycle pulse: data1 captured
tx_serial  output  1  serial line, idles high
busy  output  1  high from the capture edge until the stop bit completes
active_id  output  1  requester whose frame is in flight; holds the last value when idle

Behaviour:
- Reset (rst=0 at posedge) gives tx_serial=1, busy=0, ack0=ack1=0, active_id=0, state=IDLE, sample count=0. The round-robin pointer is set so req0 wins the first tie.
- Reset mid-frame aborts the frame. tx_serial=1 and busy=0 the next cycle. No ack is issued, and no partial byte is retried.
- All outputs are registered.
- Sample counter: width $clog2(OVERSAMPLE). It increments only on sample_tick in START, DATA or STOP. A bit period ends on a clock where sample_tick=1 and count==OVERSAMPLE-1. The count then wraps to 0.
- FSM states are IDLE, START, DATA, STOP.
- IDLE, on a clock edge with req0|req1:
  - Select the winner.
  - Latch the winner's data into the shift register.
  - Pulse ack_winner=1 for exactly one cycle.
  - Set active_id=winner, busy=1, tx_serial=0, count=0.
  - Go to START.
  - Latency from req sampled to the start-bit edge is 1 clock.
- START: tx_serial=0 for one bit period, then go to DATA with bit index=0, driving shreg[0].
- DATA:
  - At each bit-period end, the shift register shifts right and the index increments.
  - tx_serial shows the current LSB.
  - After bit DATA_BITS-1 ends, go to STOP with tx_serial=1.
- STOP:
  - tx_serial=1 for one bit period.
  - At its end, go to IDLE with busy=0.
  - A pending req in that IDLE cycle is granted on the following edge. The inter-frame gap is 1 clock.
- Arbitration:
  - With exactly one req, that requester wins.
  - With both reqs, the requester not served last wins. The pointer updates on every grant.
  - With both held continuously, grants alternate 0,1,0,1.
- Requests are level-sensitive. A requester still high after its ack is a new request.
- Any req or data change during a frame has no effect on that frame.
- sample_tick in IDLE is ignored. The count stays 0.
- Frame length is (DATA_BITS+2)*OVERSAMPLE sample_ticks. Clock length depends on tick spacing.
- ack0 and ack1 are never high in the same cycle.

Test Plan:
- Reset, then req0=1 with data0=8'hA5 and sample_tick=1 every clock. Required: ack0 pulses for 1 cycle on the edge after req is sampled. tx_serial is 0,1,0,1,0,0,1,0,1,1, each level for 16 clocks. busy is high for 160 clocks and active_id=0.
- Reset, then req0 and req1 asserted in the same cycle (data0=8'h11, data1=8'h22). Required: the 8'h11 frame is sent first with ack0, then 8'h22 with ack1. The second start bit begins 1 clock after the first stop bit ends.
- Both reqs held high for 4 frames. Required: the grant order is 0,1,0,1, and active_id matches each frame.
- Assert rst=0 during data bit 3 of a frame. Required: next cycle tx_serial=1, busy=0, no ack pulse. After release, req0 wins the first tie again.
- sample_tick every 4th clock, req1 with data1=8'h80. Required: each bit lasts 64 clocks. The line reads start 0, seven 0s, a 1, stop 1, for 640 clocks of busy.
- sample_tick pulses while idle, then req0 with 8'hFF. Required: the start bit still lasts a full 16 ticks, because the idle ticks did not advance the count.
